// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: loader FSM states and the instruction
// encodings the loader and benches need.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        RUN  = 2'd3
    } loader_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    // jal x0, 0 (spin in place)
    localparam logic [31:0] RV_HALT = 32'h0000_006f;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams an image into instruction memory and holds the
// CPU in reset until the image is in place.
// Optional feature macro PROG_LOADER_PAD_EN: when defined, memory beyond a
// short image is filled with NOPs before the CPU is released.
module prog_loader
    import rv32i_pkg::*;
#(
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] COUNT_MAX = '1;

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   wordCount_q, wordCount_d;
    logic              errOverflow_q, errOverflow_d;
    logic              sReady_q, sReady_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic              cpuRst_q, cpuRst_d;
    logic              loadDone_q, loadDone_d;
    logic              handshake;
`ifdef PROG_LOADER_PAD_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] padAddr_q, padAddr_d;
`endif

    assign handshake = s_valid && sReady_q;

    // Next-state, write-port and count logic; the stream address is the low
    // bits of word_count, and its MSB marks memory as full.
    always_comb begin
        state_d       = state_q;
        wordCount_d   = wordCount_q;
        errOverflow_d = errOverflow_q;
        memWe_d       = 1'b0;
        memAddr_d     = memAddr_q;
        memWdata_d    = memWdata_q;
`ifdef PROG_LOADER_PAD_EN
        padAddr_d     = padAddr_q;
`endif
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d       = LOAD;
                    wordCount_d   = '0;
                    errOverflow_d = 1'b0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    if (!wordCount_q[ADDR_W]) begin
                        memWe_d    = 1'b1;
                        memAddr_d  = wordCount_q[ADDR_W-1:0];
                        memWdata_d = s_data;
                    end else begin
                        errOverflow_d = 1'b1;
                    end
                    if (wordCount_q != COUNT_MAX) begin
                        wordCount_d = wordCount_q + 1'b1;
                    end
                    if (s_last) begin
`ifdef PROG_LOADER_PAD_EN
                        if (!wordCount_d[ADDR_W]) begin
                            state_d   = PAD;
                            padAddr_d = wordCount_d[ADDR_W-1:0];
                        end else begin
                            state_d = RUN;
                        end
`else
                        state_d = RUN;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_PAD_EN
            PAD: begin
                memWe_d    = 1'b1;
                memAddr_d  = padAddr_q;
                memWdata_d = RV_NOP;
                if (padAddr_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    padAddr_d = padAddr_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        sReady_d   = (state_d == LOAD);
        loadDone_d = (state_q == RUN) && (state_d == RUN);
        cpuRst_d   = !loadDone_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wordCount_q   <= '0;
            errOverflow_q <= 1'b0;
            sReady_q      <= 1'b0;
            memWe_q       <= 1'b0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            cpuRst_q      <= 1'b1;
            loadDone_q    <= 1'b0;
`ifdef PROG_LOADER_PAD_EN
            padAddr_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wordCount_q   <= wordCount_d;
            errOverflow_q <= errOverflow_d;
            sReady_q      <= sReady_d;
            memWe_q       <= memWe_d;
            memAddr_q     <= memAddr_d;
            memWdata_q    <= memWdata_d;
            cpuRst_q      <= cpuRst_d;
            loadDone_q    <= loadDone_d;
`ifdef PROG_LOADER_PAD_EN
            padAddr_q     <= padAddr_d;
`endif
        end
    end

    assign s_ready      = sReady_q;
    assign mem_we       = memWe_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign cpu_rst      = cpuRst_q;
    assign load_done    = loadDone_q;
    assign word_count   = wordCount_q;
    assign err_overflow = errOverflow_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Streams a program image into the CPU's instruction memory word by word and holds the CPU in reset until loading completes, then releases it. It sits between an external word source (UART bridge, JTAG shim, or bench driver) and the CPU's instruction memory write port. It is the writing end of instruction memory; the CPU datapath is the reading end. It replaces hierarchical memory preloading in both silicon bring-up and benches.

## Interface
Parameters:
- DEPTH, 256: instruction memory size in 32-bit words; power of two, at least 4.
- ADDR_W, $clog2(DEPTH): word-address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE and RUN, ignored otherwise.
- s_valid  in  1  source has a word.
- s_data  in  32  instruction word, little-endian as stored.
- s_last  in  1  marks the final word of the image; qualified by s_valid.
- s_ready  out  1  loader accepts a word.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- cpu_rst  out  1  active-high reset to the CPU.
- load_done  out  1  high in RUN.
- word_count  out  ADDR_W+1  number of words written from the stream in the last or current load.
- err_overflow  out  1  sticky: stream exceeded DEPTH words; cleared by rst or start.

## Operation
- States: IDLE, LOAD, PAD (only when PAD_EN), RUN.
- Reset values:
  - state = IDLE
  - cpu_rst = 1
  - s_ready = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - word_count = 0
  - err_overflow = 0
  - load_done = 0
- IDLE:
  - cpu_rst = 1, s_ready = 0.
  - start moves to LOAD and clears the address, word_count and err_overflow.
- LOAD:
  - s_ready = 1.
  - A handshake is s_valid && s_ready.
  - Each handshake with address < DEPTH registers mem_we = 1, mem_addr = address and mem_wdata = s_data. The address and word_count then increment.
  - Handshakes at address ≥ DEPTH are accepted and discarded; they set err_overflow and produce no write.
  - A handshake with s_last leaves LOAD. The next state is PAD if PAD_EN is defined and fewer than DEPTH words were written; otherwise it is RUN.
- PAD:
  - s_ready = 0.
  - Writes NOP (32'h00000013) to each remaining address, one per cycle, up to DEPTH-1. Then moves to RUN.
  - word_count does not count pad words.
- RUN:
  - cpu_rst = 0, load_done = 1.
  - start reasserts cpu_rst in the same cycle the transition registers and enters LOAD (reload).
- rst in any state, including mid-LOAD or mid-PAD:
  - Returns to IDLE with reset values at the next edge.
  - No further mem_we is issued.
  - Words already written are not erased.
- Address arithmetic is ADDR_W bits and never wraps into low memory. Overflow is detected using the word_count MSB.

## Timing
- mem_we, mem_addr and mem_wdata are registered: a write appears 1 cycle after its handshake.
- s_ready is a registered state decode. It falls the cycle after the s_last handshake.
- A back-to-back stream sustains 1 word/cycle with no bubbles.
- cpu_rst falls 1 cycle after the final mem_we cycle (last stream word or last pad word). load_done rises on the same edge.
- start in RUN: cpu_rst = 1 and s_ready = 1 from the next edge.
- start arriving in the same cycle as rst: rst wins.
- s_valid low in LOAD is a stall; no timeout.

## Configuration
- PROG_LOADER_PAD_EN
  - Defined: the PAD state exists, and unused memory is filled with NOP so a short image cannot execute stale words.
  - Undefined: there is no PAD state, LOAD goes directly to RUN, and unused memory keeps its prior contents.

## Structure
- Shared package rv32i_pkg holds:
  - loader state enum (IDLE, LOAD, PAD, RUN)
  - RV_NOP = 32'h00000013
  - RV_HALT = 32'h0000006f (JAL x0, 0), used by benches.
- No sub-module is natural. The block is a single FSM plus an address/count register.
- The CPU top-level instantiates prog_loader and ORs cpu_rst with rst into the core reset.

## Test plan
- 31-word branch-test image streamed back-to-back with s_last on word 30:
  - mem_we on 31 consecutive cycles, addresses 0..30
  - word_count = 31
  - cpu_rst falls 1 cycle after the addr-30 write
  - x5 = 10 and x15 = 20 after 1200 ns.
- Same image with s_valid toggling 1-0-1-0: writes are gapped, addresses stay contiguous 0..30, and no word is lost or duplicated.
- DEPTH=4, 6 words streamed:
  - writes at addresses 0..3 only
  - err_overflow = 1, word_count = 6
  - RUN is reached after word 5.
- PAD_EN, DEPTH=8, 3 words: addresses 3..7 receive 32'h00000013, word_count = 3, and cpu_rst falls after the addr-7 write.
- rst asserted after 2 of 5 words: IDLE next cycle, s_ready = 0, no further mem_we, cpu_rst = 1.
- In RUN, start pulse then a 2-word image: cpu_rst = 1 from the next edge, addresses 0..1 rewritten, and RUN is re-entered.
